rr_arb_mux: RTL

- Parametrised, registered N-input multiplexer with valid/ready handshakes on every input and on the output.
- Successor to the fixed 5:1, 3-bit select-driven mux. Selection is no longer an external select: a round-robin arbiter picks among valid inputs.
- One output register decouples the arbiter from the consumer.
- Sits between several producers and one shared consumer.

---
 rtl/rr_arb_mux.sv | 88 ++++++++
 1 files changed

// File: rtl/rr_arb_mux.sv
// Registered N-input round-robin arbitrating mux with valid/ready on every port.
// Optional RR_ARB_MUX_FORCE_EN adds force_en/force_sel to pin the grant to one channel.
module rr_arb_mux #(
  parameter int N_IN = 5,
  parameter int W    = 3,
  localparam int SELW = (N_IN > 2) ? $clog2(N_IN) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_IN*W-1:0]    in_data,
  input  logic [N_IN-1:0]      in_valid,
  output logic [N_IN-1:0]      in_ready,
`ifdef RR_ARB_MUX_FORCE_EN
  input  logic                 force_en,
  input  logic [SELW-1:0]      force_sel,
`endif
  output logic [W-1:0]         out_data,
  output logic [SELW-1:0]      out_sel,
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic [SELW-1:0] ptr;
  logic [SELW-1:0] winner;
  logic            found;
  logic            load;
  logic [W-1:0]    sel_data;
  int              idx;

  assign load = !out_valid || out_ready;

  // Walk from the farthest offset back to ptr+1 so the nearest valid channel wins last.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
`ifdef RR_ARB_MUX_FORCE_EN
    if (force_en) begin
      for (int i = 0; i < N_IN; i++) begin
        if (force_sel == SELW'(i) && in_valid[i]) begin
          found  = 1'b1;
          winner = SELW'(i);
        end
      end
    end else
`endif
    begin
      for (int k = N_IN; k >= 1; k--) begin
        idx = (int'(ptr) + k) % N_IN;
        if (in_valid[idx]) begin
          found  = 1'b1;
          winner = SELW'(idx);
        end
      end
    end
  end

  always_comb begin
    in_ready = '0;
    sel_data = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (winner == SELW'(i)) begin
        in_ready[i] = load && found;
        sel_data    = in_data[i*W +: W];
      end
    end
  end

  // Output register stage: holds on stall, refills or empties on load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= SELW'(N_IN - 1);
    end else if (load) begin
      if (found) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_sel   <= winner;
        ptr       <= winner;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
